riscv_commit_trace: RTL and testbench

- Parametrised commit-trace capture unit for the single-cycle RISC-V core; replaces ad-hoc per-cycle signal printing in benches.
- Taps each retired instruction: PC, instruction, rd write, writeback data.
- Buffers commits in a DEPTH-entry FIFO drained over a valid/ready port.
- Detects program end (EBREAK, self-loop, or commit timeout) and freezes capture; usable in simulation and as on-chip debug.

---
 rtl/riscv_trace_pkg.sv | 27 ++
 rtl/riscv_trace_fifo.sv | 63 ++++++
 rtl/riscv_commit_trace.sv | 150 +++++++++++++++
 tb/tb_riscv_commit_trace.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_trace_pkg.sv
// Shared constants for the commit-trace unit: halt opcodes, halt-cause codes,
// FSM state encoding and trace-entry field widths.
package riscv_trace_pkg;

  localparam int INST_W = 32;
  localparam int REG_W  = 5;

  localparam logic [INST_W-1:0] EBREAK_INST    = 32'h0010_0073;
  localparam logic [INST_W-1:0] SELF_LOOP_INST = 32'h0000_006F;

  localparam logic [1:0] HC_NONE      = 2'b00;
  localparam logic [1:0] HC_EBREAK    = 2'b01;
  localparam logic [1:0] HC_SELF_LOOP = 2'b10;
  localparam logic [1:0] HC_TIMEOUT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_HALTED  = 2'b10
  } trace_state_e;

  // Packed entry layout, MSB first: {pc, inst, rd_we, rd, wb_data}
  function automatic int entry_width(input int xlen);
    return 2 * xlen + INST_W + REG_W + 1;
  endfunction

endpackage

// File: rtl/riscv_trace_fifo.sv
// Synchronous FIFO with explicit occupancy counter; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module riscv_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_eff, pop_eff;

  always_comb begin
    pop_eff  = pop && (level_q != '0);
    push_eff = push && ((level_q != LVL_FULL) || pop_eff);
    wptr_d   = wptr_q + PTR_W'(push_eff);
    rptr_d   = rptr_q + PTR_W'(pop_eff);
    level_d  = level_q;
    case ({push_eff, pop_eff})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is data-only; the empty mask below keeps it invisible after reset
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wptr_q] <= push_data;
  end

  assign head_valid = (level_q != '0);
  assign head_data  = head_valid ? mem_q[rptr_q] : '0;
  assign full       = (level_q == LVL_FULL);
  assign level      = level_q;

endmodule

// File: rtl/riscv_commit_trace.sv
// Commit-trace capture: FSM, halt detection and counters around a trace FIFO.
// Define RISCV_TRACE_FILTER_EN to capture only commits that write a non-x0 rd.
module riscv_commit_trace
  import riscv_trace_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   commit_valid,
  input  logic [XLEN-1:0]        commit_pc,
  input  logic [31:0]            commit_inst,
  input  logic                   commit_rd_we,
  input  logic [4:0]             commit_rd,
  input  logic [XLEN-1:0]        commit_wb_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [XLEN-1:0]        rd_pc,
  output logic [31:0]            rd_inst,
  output logic                   rd_we,
  output logic [4:0]             rd_rd,
  output logic [XLEN-1:0]        rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   halted,
  output logic [1:0]             halt_cause,
  output logic [CNT_W-1:0]       cycle_count
);

  localparam int ENTRY_W = entry_width(XLEN);
  localparam int IDLE_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);

  trace_state_e      state_q, state_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;

  logic               observe, push_req, push, pop, drop;
  logic               head_valid, fifo_full;
  logic [ENTRY_W-1:0] push_entry, head_entry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign push_entry = {commit_pc, commit_inst, commit_rd_we, commit_rd, commit_wb_data};

  always_comb begin
    observe = (state_q == ST_CAPTURE) && commit_valid;
`ifdef RISCV_TRACE_FILTER_EN
    push_req = observe && commit_rd_we && (commit_rd != '0);
`else
    push_req = observe;
`endif
    pop  = head_valid && rd_ready;
    // A full FIFO only loses the entry when nothing leaves in the same cycle
    drop = push_req && fifo_full && !pop;
    push = push_req && !drop;
  end

  riscv_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_entry),
    .full       (fifo_full),
    .level      (level)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    cycle_d  = cycle_q;
    idle_d   = idle_q;
    idle_inc = idle_q + IDLE_W'(1);
    drop_d   = drop ? sat_inc(drop_q) : drop_q;
    ovf_d    = ovf_q | drop;
    case (state_q)
      ST_IDLE: begin
        idle_d = '0;
        if (enable) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cycle_d = sat_inc(cycle_q);
        if (commit_valid) begin
          idle_d = '0;
          if (commit_inst == EBREAK_INST) begin
            state_d = ST_HALTED;
            cause_d = HC_EBREAK;
          end else if (commit_inst == SELF_LOOP_INST) begin
            state_d = ST_HALTED;
            cause_d = HC_SELF_LOOP;
          end
        end else if (TIMEOUT != 0) begin
          // idle_q counts quiet edges since the last commit or capture start
          if (idle_inc == IDLE_LIMIT) begin
            state_d = ST_HALTED;
            cause_d = HC_TIMEOUT;
          end else begin
            idle_d = idle_inc;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cause_q <= HC_NONE;
      cycle_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cycle_q <= cycle_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      idle_q  <= idle_d;
    end
  end

  assign rd_valid = head_valid;
  assign {rd_pc, rd_inst, rd_we, rd_rd, rd_data} = head_entry;
  assign overflow    = ovf_q;
  assign drop_count  = drop_q;
  assign halted      = (state_q == ST_HALTED);
  assign halt_cause  = cause_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_riscv_commit_trace.sv
// Self-checking bench for riscv_commit_trace: directed scenarios plus
// randomized segments compared every cycle against a queue-based model.
module tb_riscv_commit_trace;
  import riscv_trace_pkg::*;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 6;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             commit_valid = 1'b0;
  logic [31:0]      commit_pc = '0;
  logic [31:0]      commit_inst = '0;
  logic             commit_rd_we = 1'b0;
  logic [4:0]       commit_rd = '0;
  logic [31:0]      commit_wb_data = '0;
  logic             rd_ready = 1'b0;
  logic             rd_valid;
  logic [31:0]      rd_pc, rd_inst, rd_data;
  logic             rd_we;
  logic [4:0]       rd_rd;
  logic [4:0]       level;
  logic             overflow, halted;
  logic [CNT_W-1:0] drop_count, cycle_count;
  logic [1:0]       halt_cause;

  riscv_commit_trace #(
    .XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_rd_we(commit_rd_we), .commit_rd(commit_rd), .commit_wb_data(commit_wb_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_inst(rd_inst),
    .rd_we(rd_we), .rd_rd(rd_rd), .rd_data(rd_data), .level(level),
    .overflow(overflow), .drop_count(drop_count), .halted(halted),
    .halt_cause(halt_cause), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Model: 0 idle, 1 capture, 2 halted
  ent_t q[$];
  int   m_st = 0, m_cause = 0, m_cyc = 0, m_drops = 0, m_ovf = 0;
  int   edge_no = 0, last_ev = 0;
  int   n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_st = 0; m_cause = 0; m_cyc = 0; m_drops = 0; m_ovf = 0;
    edge_no = 0; last_ev = 0;
  endtask

  task automatic model_step();
    bit   want;
    ent_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    edge_no++;
    if (q.size() != 0 && rd_ready) q.delete(0);
    if (m_st == 0) begin
      if (enable) begin m_st = 1; last_ev = edge_no; end
    end else if (m_st == 1) begin
      m_cyc = (m_cyc == CMAX) ? CMAX : m_cyc + 1;
      if (commit_valid) begin
`ifdef RISCV_TRACE_FILTER_EN
        want = commit_rd_we && (commit_rd != 0);
`else
        want = 1'b1;
`endif
        if (want) begin
          if (q.size() < DEPTH) begin
            e.pc = commit_pc; e.inst = commit_inst; e.we = commit_rd_we;
            e.rd = commit_rd; e.data = commit_wb_data;
            q.push_back(e);
          end else begin
            m_drops = (m_drops == CMAX) ? CMAX : m_drops + 1;
            m_ovf = 1;
          end
        end
        last_ev = edge_no;
        if (commit_inst == EBREAK_INST) begin m_st = 2; m_cause = 1; end
        else if (commit_inst == SELF_LOOP_INST) begin m_st = 2; m_cause = 2; end
      end else if (edge_no - last_ev == TIMEOUT) begin
        m_st = 2; m_cause = 3;
      end
    end
  endtask

  // Compare process: DUT outputs against the model after every active edge
  always @(negedge clk) begin
    chk("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
    chk("level", 64'(level), 64'(q.size()));
    if (q.size() != 0) begin
      chk("rd_pc", 64'(rd_pc), 64'(q[0].pc));
      chk("rd_inst", 64'(rd_inst), 64'(q[0].inst));
      chk("rd_we", 64'(rd_we), 64'(q[0].we));
      chk("rd_rd", 64'(rd_rd), 64'(q[0].rd));
      chk("rd_data", 64'(rd_data), 64'(q[0].data));
    end
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drops));
    chk("halted", 64'(halted), 64'(m_st == 2));
    chk("halt_cause", 64'(halt_cause), 64'(m_cause));
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
  end

  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic we, input logic [4:0] rd, input logic [31:0] data);
    commit_valid = v; commit_pc = pc; commit_inst = inst;
    commit_rd_we = we; commit_rd = rd; commit_wb_data = data;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, ".level"}, 64'(level), 64'd0);
    chk({tag, ".rd_pc"}, 64'(rd_pc), 64'd0);
    chk({tag, ".rd_inst"}, 64'(rd_inst), 64'd0);
    chk({tag, ".rd_we"}, 64'(rd_we), 64'd0);
    chk({tag, ".rd_rd"}, 64'(rd_rd), 64'd0);
    chk({tag, ".rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, ".overflow"}, 64'(overflow), 64'd0);
    chk({tag, ".drop_count"}, 64'(drop_count), 64'd0);
    chk({tag, ".halted"}, 64'(halted), 64'd0);
    chk({tag, ".halt_cause"}, 64'(halt_cause), 64'd0);
    chk({tag, ".cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  // Called just after a falling edge: reset asserts mid-cycle, releases a cycle later
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned cv_pct, rdy_pct, halt_odds;
    logic [31:0] inst;
    logic [5:0]  frozen;

    @(negedge clk); #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Three ALU commits drained in order with rd_ready held high
    enable = 1'b1; tick(); enable = 1'b0;
    rd_ready = 1'b1;
    drive(1, 32'h0, 32'h0050_0093, 1, 5'd1, 32'd5); tick();
    chk("t1.first_rd", 64'(rd_rd), 64'd1); chk("t1.first_data", 64'(rd_data), 64'd5);
    drive(1, 32'h4, 32'h00A0_0113, 1, 5'd2, 32'd10); tick();
    chk("t1.second_rd", 64'(rd_rd), 64'd2); chk("t1.second_data", 64'(rd_data), 64'd10);
    drive(1, 32'h8, 32'h0020_81B3, 1, 5'd3, 32'd15); tick();
    chk("t1.third_rd", 64'(rd_rd), 64'd3); chk("t1.third_data", 64'(rd_data), 64'd15);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("t1.level_empty", 64'(level), 64'd0);

    // Overflow: 20 commits into a 16-deep FIFO, then push together with pop
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 32'h0000_0013 | (32'(i + 1) << 7), 1, 5'(i + 1), 32'(i)); tick();
    end
    chk("t2.level_full", 64'(level), 64'd16);
    chk("t2.overflow", 64'(overflow), 64'd1);
    chk("t2.drops", 64'(drop_count), 64'd4);
    rd_ready = 1'b1;
    drive(1, 32'h200, 32'h0000_0093, 1, 5'd1, 32'd99); tick();
    chk("t2.level_pushpop", 64'(level), 64'd16);
    chk("t2.drops_pushpop", 64'(drop_count), 64'd4);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("t2.drained", 64'(level), 64'd0);
    chk("t2.timeout_cause", 64'(halt_cause), 64'd3);

    // Timeout exactly TIMEOUT edges after the last commit
    do_reset();
    enable = 1'b1; tick(); enable = 1'b0;
    drive(1, 32'h0, 32'h0050_0093, 1, 5'd1, 32'd5); tick();
    drive(1, 32'h4, 32'h00A0_0113, 1, 5'd2, 32'd10); tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      chk("t3.halted_at_k", 64'(halted), 64'(k == TIMEOUT));
    end
    chk("t3.cause", 64'(halt_cause), 64'd3);
    chk("t3.cycles", 64'(cycle_count), 64'd10);
    tick(); tick();
    chk("t3.cycles_frozen", 64'(cycle_count), 64'd10);

    // EBREAK at PC 0x18 halts and is itself captured
    do_reset();
    enable = 1'b1; tick(); enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'(4 * i), 32'h0010_0093, 1, 5'd1, 32'(i)); tick();
    end
    drive(1, 32'h18, EBREAK_INST, 0, 5'd0, 32'd0); tick();
    chk("t4.halted", 64'(halted), 64'd1);
    chk("t4.cause", 64'(halt_cause), 64'd1);
    chk("t4.cycles", 64'(cycle_count), 64'd7);
`ifndef RISCV_TRACE_FILTER_EN
    chk("t4.ebreak_pc", 64'(rd_pc), 64'h18);
    chk("t4.ebreak_inst", 64'(rd_inst), 64'h0010_0073);
`endif
    rd_ready = 1'b0;
    frozen = level[5:0] + 6'd0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h40 + 32'(4 * i), 32'h0010_0093, 1, 5'd1, 32'd7); tick();
    end
    chk("t4.no_push_after_halt", 64'(level), 64'(frozen));
    chk("t4.cycles_frozen", 64'(cycle_count), 64'd7);

    // Asynchronous reset in the middle of a drain with level 5
    do_reset();
    enable = 1'b1; tick(); enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h80 + 32'(4 * i), 32'h0030_0093, 1, 5'(i + 1), 32'(i)); tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    rd_ready = 1'b1; tick();
    chk("t5.level5", 64'(level), 64'd5);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero("t5.async");
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300, 32'h0000_0093, 1, 5'd1, 32'd1); tick();
    end
    chk("t5.ignored_idle", 64'(level), 64'd0);
    enable = 1'b1; tick(); enable = 1'b0;
    chk("t5.enable_edge_ignored", 64'(level), 64'd0);
    tick();
    chk("t5.capture_after_enable", 64'(level), 64'd1);

    // Filter scenario: sw, addi x0, addi x4=256
    do_reset();
    rd_ready = 1'b0;
    enable = 1'b1; tick(); enable = 1'b0;
    drive(1, 32'h0, 32'h0020_A023, 0, 5'd7, 32'd0); tick();
    drive(1, 32'h4, 32'h0000_0013, 1, 5'd0, 32'd0); tick();
    drive(1, 32'h8, 32'h1000_0213, 1, 5'd4, 32'd256); tick();
    drive(0, 0, 0, 0, 0, 0);
`ifdef RISCV_TRACE_FILTER_EN
    chk("t6.level", 64'(level), 64'd1);
    chk("t6.rd", 64'(rd_rd), 64'd4);
    chk("t6.data", 64'(rd_data), 64'd256);
`else
    chk("t6.level", 64'(level), 64'd3);
`endif

    // Randomized segments with varying commit density, drain rate and halts
    for (int s = 0; s < 9; s++) begin
      do_reset();
      cv_pct    = (s % 3 == 0) ? 20 : ((s % 3 == 1) ? 60 : 95);
      rdy_pct   = (s / 3 == 0) ? 10 : ((s / 3 == 1) ? 50 : 90);
      halt_odds = (s % 2 == 0) ? 0 : 120;
      for (int c = 0; c < 300; c++) begin
        enable = ($urandom_range(0, 9) < 3);
        inst = $urandom;
        if (halt_odds != 0 && $urandom_range(0, halt_odds - 1) == 0)
          inst = $urandom_range(0, 1) ? EBREAK_INST : SELF_LOOP_INST;
        drive($urandom_range(0, 99) < cv_pct, $urandom, inst, 1'($urandom),
              5'($urandom), $urandom);
        rd_ready = ($urandom_range(0, 99) < rdy_pct);
        if ($urandom_range(0, 299) == 0) do_reset();
        else tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
